// File: rtl/rs_table_pkg.sv
// Shared sizing for the reservation station: N, RS_NUM_ENTRIES, PR_TAG_W and PAYLOAD_W macros.
// Defining RS_WAKEUP_ISSUE_EN lets a CDB match issue in the same cycle it arrives.
`ifndef N
`define N 2
`endif
`ifndef RS_NUM_ENTRIES
`define RS_NUM_ENTRIES 8
`endif
`ifndef PR_TAG_W
`define PR_TAG_W 6
`endif
`ifndef PAYLOAD_W
`define PAYLOAD_W 32
`endif

package rs_table_pkg;
  localparam int DEF_N         = `N;
  localparam int DEF_RS_SIZE   = `RS_NUM_ENTRIES;
  localparam int DEF_TAG_W     = `PR_TAG_W;
  localparam int DEF_PAYLOAD_W = `PAYLOAD_W;
endpackage

// File: rtl/priority_selector.sv
// Picks up to REQS requesters per cycle: even slices take the lowest remaining bit,
// odd slices the highest, so lane 0 and lane 1 grow from opposite ends.
module priority_selector #(
  parameter int REQS  = 2,
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]      i_req,
  output logic [REQS*WIDTH-1:0] o_grant
);

  logic [WIDTH-1:0] w_remain;
  logic             w_found;
  int               w_idx;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_remain = i_req;
    o_grant  = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < REQS; k++) begin
      w_found = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        w_idx = (k % 2 == 0) ? j : (WIDTH - 1 - j);
        if (!w_found && w_remain[w_idx]) begin
          o_grant[k*WIDTH + w_idx] = 1'b1;
          w_remain[w_idx]          = 1'b0;
          w_found                  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rs_entry.sv
// One reservation-station slot: operand tags, ready bits, N-way CDB wakeup and gated outputs.
// With RS_WAKEUP_ISSUE_EN defined, live CDB matches also count toward this cycle's ready.
module rs_entry #(
  parameter int N         = 2,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_squash,
  input  logic [N-1:0]           i_alloc_sel,
  input  logic [N*TAG_W-1:0]     i_src1_tag,
  input  logic [N-1:0]           i_src1_rdy,
  input  logic [N*TAG_W-1:0]     i_src2_tag,
  input  logic [N-1:0]           i_src2_rdy,
  input  logic [N*TAG_W-1:0]     i_dest_tag,
  input  logic [N*PAYLOAD_W-1:0] i_payload,
  input  logic [N-1:0]           i_cdb_valid,
  input  logic [N*TAG_W-1:0]     i_cdb_tag,
  input  logic                   i_issue,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic [TAG_W-1:0]       o_dest_tag,
  output logic [PAYLOAD_W-1:0]   o_payload
);

  function automatic logic cdb_hit(input logic [TAG_W-1:0] tag, input logic [N-1:0] cv,
                                   input logic [N*TAG_W-1:0] ct);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < N; k++)
      if (cv[k] && (ct[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    return hit;
  endfunction

  logic                 r_valid, r_src1_rdy, r_src2_rdy;
  logic [TAG_W-1:0]     r_src1_tag, r_src2_tag, r_dest_tag;
  logic [PAYLOAD_W-1:0] r_payload;

  logic                 w_alloc, w_in_src1_rdy, w_in_src2_rdy;
  logic [TAG_W-1:0]     w_in_src1_tag, w_in_src2_tag, w_in_dest_tag;
  logic [PAYLOAD_W-1:0] w_in_payload;
  logic                 w_src1_hit, w_src2_hit, w_src1_ok, w_src2_ok;

  // At most one dispatch lane selects this slot, so an OR of masked lanes is the mux.
  always_comb begin
    w_in_src1_tag = '0;
    w_in_src2_tag = '0;
    w_in_dest_tag = '0;
    w_in_payload  = '0;
    w_in_src1_rdy = 1'b0;
    w_in_src2_rdy = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_alloc_sel[k]) begin
        w_in_src1_tag = w_in_src1_tag | i_src1_tag[k*TAG_W +: TAG_W];
        w_in_src2_tag = w_in_src2_tag | i_src2_tag[k*TAG_W +: TAG_W];
        w_in_dest_tag = w_in_dest_tag | i_dest_tag[k*TAG_W +: TAG_W];
        w_in_payload  = w_in_payload  | i_payload[k*PAYLOAD_W +: PAYLOAD_W];
        w_in_src1_rdy = w_in_src1_rdy | i_src1_rdy[k];
        w_in_src2_rdy = w_in_src2_rdy | i_src2_rdy[k];
      end
    end
  end

  assign w_alloc    = |i_alloc_sel;
  assign w_src1_hit = cdb_hit(w_alloc ? w_in_src1_tag : r_src1_tag, i_cdb_valid, i_cdb_tag);
  assign w_src2_hit = cdb_hit(w_alloc ? w_in_src2_tag : r_src2_tag, i_cdb_valid, i_cdb_tag);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_squash) r_valid <= 1'b0;
    else if (w_alloc)        r_valid <= 1'b1;
    else if (i_issue)        r_valid <= 1'b0;
  end

  // NOTE: operand and payload fields carry no reset; r_valid gates every use of them.
  always_ff @(posedge i_clock) begin
    if (w_alloc) begin
      r_src1_tag <= w_in_src1_tag;
      r_src2_tag <= w_in_src2_tag;
      r_dest_tag <= w_in_dest_tag;
      r_payload  <= w_in_payload;
      r_src1_rdy <= w_in_src1_rdy | w_src1_hit;
      r_src2_rdy <= w_in_src2_rdy | w_src2_hit;
    end else begin
      if (w_src1_hit) r_src1_rdy <= 1'b1;
      if (w_src2_hit) r_src2_rdy <= 1'b1;
    end
  end

`ifdef RS_WAKEUP_ISSUE_EN
  assign w_src1_ok = r_src1_rdy | w_src1_hit;
  assign w_src2_ok = r_src2_rdy | w_src2_hit;
`else
  assign w_src1_ok = r_src1_rdy;
  assign w_src2_ok = r_src2_rdy;
`endif

  assign o_valid    = r_valid;
  assign o_ready    = r_valid & w_src1_ok & w_src2_ok;
  assign o_dest_tag = i_issue ? r_dest_tag : '0;
  assign o_payload  = i_issue ? r_payload  : '0;

endmodule

// File: rtl/rs_table.sv
// N-wide reservation station: allocation into free slots, CDB wakeup and N-way issue select.
// RS_WAKEUP_ISSUE_EN (see rs_entry) folds same-cycle CDB matches into issue readiness.
module rs_table
  import rs_table_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int RS_SIZE   = DEF_RS_SIZE,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  logic [N-1:0]                 disp_valid,
  input  logic [N*TAG_W-1:0]           disp_src1_tag,
  input  logic [N-1:0]                 disp_src1_rdy,
  input  logic [N*TAG_W-1:0]           disp_src2_tag,
  input  logic [N-1:0]                 disp_src2_rdy,
  input  logic [N*TAG_W-1:0]           disp_dest_tag,
  input  logic [N*PAYLOAD_W-1:0]       disp_payload,
  input  logic [N-1:0]                 cdb_valid,
  input  logic [N*TAG_W-1:0]           cdb_tag,
  output logic [$clog2(RS_SIZE+1)-1:0] free_count,
  output logic [N-1:0]                 issue_valid,
  output logic [N*TAG_W-1:0]           issue_dest_tag,
  output logic [N*PAYLOAD_W-1:0]       issue_payload
);

  logic [RS_SIZE-1:0]           w_valid, w_ready;
  logic [N*RS_SIZE-1:0]         w_alloc_grant, w_issue_grant;
  logic [RS_SIZE*TAG_W-1:0]     w_ent_dest;
  logic [RS_SIZE*PAYLOAD_W-1:0] w_ent_payload;

  priority_selector #(.REQS(N), .WIDTH(RS_SIZE)) u_alloc_sel (
    .i_req   (~w_valid),
    .o_grant (w_alloc_grant)
  );

  priority_selector #(.REQS(N), .WIDTH(RS_SIZE)) u_issue_sel (
    .i_req   (w_ready),
    .o_grant (w_issue_grant)
  );

  for (genvar e = 0; e < RS_SIZE; e++) begin : g_entry
    logic [N-1:0] w_sel, w_iss;
    for (genvar k = 0; k < N; k++) begin : g_lane
      assign w_sel[k] = disp_valid[k] & w_alloc_grant[k*RS_SIZE + e];
      assign w_iss[k] = w_issue_grant[k*RS_SIZE + e];
    end

    rs_entry #(.N(N), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)) u_entry (
      .i_clock     (clock),
      .i_reset     (reset),
      .i_squash    (squash),
      .i_alloc_sel (w_sel),
      .i_src1_tag  (disp_src1_tag),
      .i_src1_rdy  (disp_src1_rdy),
      .i_src2_tag  (disp_src2_tag),
      .i_src2_rdy  (disp_src2_rdy),
      .i_dest_tag  (disp_dest_tag),
      .i_payload   (disp_payload),
      .i_cdb_valid (cdb_valid),
      .i_cdb_tag   (cdb_tag),
      .i_issue     (|w_iss),
      .o_valid     (w_valid[e]),
      .o_ready     (w_ready[e]),
      .o_dest_tag  (w_ent_dest[e*TAG_W +: TAG_W]),
      .o_payload   (w_ent_payload[e*PAYLOAD_W +: PAYLOAD_W])
    );
  end

  // Entry outputs are already zero unless issued, so the issue mux is a plain OR per lane.
  always_comb begin
    issue_valid    = '0;
    issue_dest_tag = '0;
    issue_payload  = '0;
    for (int k = 0; k < N; k++) begin
      for (int e = 0; e < RS_SIZE; e++) begin
        if (w_issue_grant[k*RS_SIZE + e]) begin
          issue_valid[k] = 1'b1;
          issue_dest_tag[k*TAG_W +: TAG_W] = issue_dest_tag[k*TAG_W +: TAG_W]
                                             | w_ent_dest[e*TAG_W +: TAG_W];
          issue_payload[k*PAYLOAD_W +: PAYLOAD_W] = issue_payload[k*PAYLOAD_W +: PAYLOAD_W]
                                                    | w_ent_payload[e*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end

  always_comb begin
    free_count = '0;
    for (int e = 0; e < RS_SIZE; e++)
      if (!w_valid[e]) free_count = free_count + 1'b1;
  end

  // Dispatch lanes must be packed from lane 0 and never outnumber free slots.
  a_disp_legal : assert property (@(posedge clock) disable iff (reset || squash)
    ($countones(disp_valid) <= int'(free_count)) &&
    ((disp_valid & (disp_valid + 1'b1)) == '0));

endmodule

// File: tb/tb_rs_table.sv
// Directed bench for rs_table (N=2, RS_SIZE=8, TAG_W=6, PAYLOAD_W=32): vector table plus
// hand-written reset-drop and wakeup-latency sequences.
module tb_rs_table;

  logic         clock = 1'b0;
  logic         reset, squash;
  logic [1:0]   disp_valid, disp_src1_rdy, disp_src2_rdy, cdb_valid;
  logic [11:0]  disp_src1_tag, disp_src2_tag, disp_dest_tag, cdb_tag;
  logic [63:0]  disp_payload;
  logic [3:0]   free_count;
  logic [1:0]   issue_valid;
  logic [11:0]  issue_dest_tag;
  logic [63:0]  issue_payload;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  rs_table #(.N(2), .RS_SIZE(8), .TAG_W(6), .PAYLOAD_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .squash         (squash),
    .disp_valid     (disp_valid),
    .disp_src1_tag  (disp_src1_tag),
    .disp_src1_rdy  (disp_src1_rdy),
    .disp_src2_tag  (disp_src2_tag),
    .disp_src2_rdy  (disp_src2_rdy),
    .disp_dest_tag  (disp_dest_tag),
    .disp_payload   (disp_payload),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .free_count     (free_count),
    .issue_valid    (issue_valid),
    .issue_dest_tag (issue_dest_tag),
    .issue_payload  (issue_payload)
  );

  typedef struct packed {
    logic             sq;
    logic [1:0]       dv;
    logic [1:0][5:0]  s1t;
    logic [1:0]       s1r;
    logic [1:0][5:0]  s2t;
    logic [1:0]       s2r;
    logic [1:0][5:0]  dt;
    logic [1:0][31:0] pl;
    logic [1:0]       cv;
    logic [1:0][5:0]  ct;
    logic [3:0]       e_free;
    logic [1:0]       e_iv;
    logic [1:0][5:0]  e_dt;
    logic [1:0][31:0] e_pl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t ex(input logic [3:0] f, input logic [1:0] iv,
                              input logic [5:0] d1, input logic [5:0] d0,
                              input logic [31:0] p1, input logic [31:0] p0);
    vec_t v = '0;
    v.e_free = f;
    v.e_iv   = iv;
    v.e_dt   = {d1, d0};
    v.e_pl   = {p1, p0};
    return v;
  endfunction

  function automatic vec_t dsp(input vec_t vi, input int ln, input logic [5:0] s1t,
                               input logic s1r, input logic [5:0] s2t, input logic s2r,
                               input logic [5:0] dt, input logic [31:0] pl);
    vec_t v = vi;
    v.dv[ln]  = 1'b1;
    v.s1t[ln] = s1t;
    v.s1r[ln] = s1r;
    v.s2t[ln] = s2t;
    v.s2r[ln] = s2r;
    v.dt[ln]  = dt;
    v.pl[ln]  = pl;
    return v;
  endfunction

  function automatic vec_t cdb(input vec_t vi, input int ln, input logic [5:0] tag);
    vec_t v = vi;
    v.cv[ln] = 1'b1;
    v.ct[ln] = tag;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    squash        = v.sq;
    disp_valid    = v.dv;
    disp_src1_tag = v.s1t;
    disp_src1_rdy = v.s1r;
    disp_src2_tag = v.s2t;
    disp_src2_rdy = v.s2r;
    disp_dest_tag = v.dt;
    disp_payload  = v.pl;
    cdb_valid     = v.cv;
    cdb_tag       = v.ct;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, "_free"},    free_count,     v.e_free);
    check({tag, "_ivalid"},  issue_valid,    v.e_iv);
    check({tag, "_dest"},    issue_dest_tag, v.e_dt);
    check({tag, "_payload"}, issue_payload,  v.e_pl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lat;
    int   exp_lat;
    logic [5:0]  lat_dest;
    logic [31:0] lat_pl;

    reset = 1'b1;
    drive('0);
    @(negedge clock);
    @(negedge clock);
    #1;
    check_outs("reset", ex(8, 2'b00, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b0;

    // Expected outputs are those seen in the row's own cycle, before its inputs are clocked in.
    repeat (5) vecs.push_back(ex(8, 2'b00, 0, 0, 0, 0));
    vecs.push_back(dsp(dsp(ex(8, 2'b00, 0, 0, 0, 0), 0, 0, 1, 0, 1, 5, 'hA5), 1, 0, 1, 0, 1, 9, 'h99));
    vecs.push_back(ex(6, 2'b11, 9, 5, 'h99, 'hA5));
    vecs.push_back(ex(8, 2'b00, 0, 0, 0, 0));
    vecs.push_back(dsp(ex(8, 2'b00, 0, 0, 0, 0), 0, 12, 0, 0, 1, 3, 'h1200));
    vecs.push_back(cdb(ex(7, 2'b00, 0, 0, 0, 0), 0, 13));
    vecs.push_back(cdb(ex(7, 2'b00, 0, 0, 0, 0), 1, 12));
    vecs.push_back(ex(7, 2'b01, 0, 3, 0, 'h1200));
    vecs.push_back(cdb(dsp(ex(8, 2'b00, 0, 0, 0, 0), 0, 20, 0, 21, 1, 7, 'h2000), 0, 20));
    vecs.push_back(ex(7, 2'b01, 0, 7, 0, 'h2000));
    vecs.push_back(dsp(dsp(ex(8, 2'b00, 0, 0, 0, 0), 0, 30, 0, 0, 1, 40, 'h300), 1, 31, 0, 0, 1, 41, 'h301));
    vecs.push_back(dsp(dsp(ex(6, 2'b00, 0, 0, 0, 0), 0, 32, 0, 0, 1, 42, 'h302), 1, 33, 0, 0, 1, 43, 'h303));
    vecs.push_back(dsp(dsp(ex(4, 2'b00, 0, 0, 0, 0), 0, 34, 0, 0, 1, 44, 'h304), 1, 35, 0, 0, 1, 45, 'h305));
    vecs.push_back(dsp(dsp(ex(2, 2'b00, 0, 0, 0, 0), 0, 36, 0, 0, 1, 46, 'h306), 1, 37, 0, 0, 1, 47, 'h307));
    vecs.push_back(cdb(cdb(ex(0, 2'b00, 0, 0, 0, 0), 0, 33), 1, 36));
    vecs.push_back(ex(0, 2'b11, 43, 46, 'h303, 'h306));
    vecs.push_back(cdb(cdb(dsp(ex(2, 2'b00, 0, 0, 0, 0), 0, 0, 1, 0, 1, 50, 'h500), 0, 30), 1, 37));
    vecs.push_back(ex(1, 2'b11, 47, 40, 'h307, 'h300));
    vecs.push_back(ex(3, 2'b01, 0, 50, 0, 'h500));
    v = dsp(dsp(ex(4, 2'b00, 0, 0, 0, 0), 0, 0, 1, 0, 1, 60, 'h600), 1, 0, 1, 0, 1, 61, 'h601);
    v.sq = 1'b1;
    vecs.push_back(v);
    vecs.push_back(ex(8, 2'b00, 0, 0, 0, 0));
    vecs.push_back(ex(8, 2'b00, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      #1;
      check_outs($sformatf("row%0d", i), vecs[i]);
    end

    // Reset in the same cycle as dispatch and CDB traffic drops all of it.
    @(negedge clock);
    drive(dsp(dsp(ex(0, 0, 0, 0, 0, 0), 0, 9, 0, 0, 1, 1, 'h1), 1, 10, 0, 0, 1, 2, 'h2));
    #1;
    check("rstdrop_pre_free", free_count, 8);
    @(negedge clock);
    reset = 1'b1;
    drive(dsp(cdb(cdb(ex(0, 0, 0, 0, 0, 0), 0, 9), 1, 10), 0, 0, 1, 0, 1, 22, 'h22));
    #1;
    check("rstdrop_held_free", free_count, 6);
    @(negedge clock);
    reset = 1'b0;
    drive('0);
    #1;
    check_outs("rstdrop_post", ex(8, 2'b00, 0, 0, 0, 0));
    @(negedge clock);
    #1;
    check_outs("rstdrop_post2", ex(8, 2'b00, 0, 0, 0, 0));

    // Wakeup latency on src2, measured from the CDB cycle with a bounded wait.
`ifdef RS_WAKEUP_ISSUE_EN
    exp_lat = 0;
`else
    exp_lat = 1;
`endif
    @(negedge clock);
    drive(dsp(ex(0, 0, 0, 0, 0, 0), 0, 0, 1, 11, 0, 15, 'hF00D));
    @(negedge clock);
    drive('0);
    @(negedge clock);
    drive(cdb(ex(0, 0, 0, 0, 0, 0), 0, 11));
    #1;
    lat = -1;
    lat_dest = '0;
    lat_pl = '0;
    if (issue_valid[0]) begin
      lat = 0;
      lat_dest = issue_dest_tag[5:0];
      lat_pl = issue_payload[31:0];
    end
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(negedge clock);
      drive('0);
      #1;
      if (issue_valid[0]) begin
        lat = c;
        lat_dest = issue_dest_tag[5:0];
        lat_pl = issue_payload[31:0];
      end
    end
    check("wake_latency", lat, exp_lat);
    check("wake_dest", lat_dest, 15);
    check("wake_payload", lat_pl, 'hF00D);
    @(negedge clock);
    #1;
    check_outs("final_idle", ex(8, 2'b00, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_table.md
Name: rs_table

Overview:
- N-wide reservation station: entry storage, tag wakeup and issue selection.
- Sits between dispatch and the functional units.
- Allocates up to N dispatched instructions per cycle into free entries and captures CDB broadcasts for operand wakeup.
- Selects up to N ready entries per cycle for issue. Both allocation and issue use the team's existing priority_selector.

Parameters:
- N, `N: dispatch, issue and CDB width.
- RS_SIZE, `RS_NUM_ENTRIES: number of entries.
- TAG_W, 6: physical register tag width.
- PAYLOAD_W, 32: opaque per-instruction payload width (opcode, PC, immediates).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  flush all entries (mispredict)
- disp_valid  in  N  dispatch lane valids; packed from lane 0
- disp_src1_tag  in  N*TAG_W  source 1 tags
- disp_src1_rdy  in  N  source 1 already ready
- disp_src2_tag  in  N*TAG_W  source 2 tags
- disp_src2_rdy  in  N  source 2 already ready
- disp_dest_tag  in  N*TAG_W  destination tags
- disp_payload  in  N*PAYLOAD_W  payloads
- cdb_valid  in  N  CDB lane valids
- cdb_tag  in  N*TAG_W  broadcast tags
- free_count  out  $clog2(RS_SIZE+1)  free entries this cycle
- issue_valid  out  N  issue lane valids
- issue_dest_tag  out  N*TAG_W  issued destination tags
- issue_payload  out  N*PAYLOAD_W  issued payloads

Behaviour:
- Entry state: valid, src1_tag, src1_rdy, src2_tag, src2_rdy, dest_tag, payload.
- Reset / squash:
  - On a posedge with reset or squash high, all valids clear. Other fields are don't-care.
  - Dispatch and CDB inputs in that cycle are dropped.
  - reset and squash have equal effect.
- Reset outputs: free_count=RS_SIZE, issue_valid=0, issue_dest_tag=0, issue_payload=0.
- free_count: combinational popcount of ~valid from current registers. It does not credit same-cycle issues.
- Allocation:
  - A priority_selector (REQS=N, WIDTH=RS_SIZE) runs on ~valid.
  - Dispatch lane k writes the entry in grant slice k: lane 0 gets the lowest free index, lane 1 the highest, lane 2 the next lowest, and so on.
  - Upstream guarantees popcount(disp_valid) <= free_count and packed lanes.
  - A violation is an assertion failure (simulation only). No entry is overwritten.
- Wakeup:
  - Each valid entry compares src tags against every cdb lane with cdb_valid=1. A match sets rdy at the next edge.
  - Dispatch bypass is always on: an incoming operand whose tag matches a same-cycle CDB tag is written with rdy=1.
- Issue:
  - ready_vec = valid & src1_rdy & src2_rdy.
  - A second priority_selector (REQS=N, WIDTH=RS_SIZE) runs on ready_vec.
  - issue_valid[k] = |grant slice k. Outputs are an AND-OR mux of entries by grant, so they are zero when the lane is idle.
  - Outputs are combinational from registers. Issued entries clear valid at the next edge.
  - Functional units always accept; there is no stall.
- Latency: an entry dispatched ready at edge t can issue in cycle t+1. A CDB match in cycle t sets rdy at edge t+1, with issue in cycle t+1 (default build).
- Freed slots: a slot freed by issue in cycle t is allocatable from cycle t+1 only.
- Empty / full: RS empty gives issue_valid=0. RS full gives free_count=0, and upstream must hold dispatch.

Optional Feature:
- RS_WAKEUP_ISSUE_EN defined:
  - ready_vec also ORs same-cycle CDB matches into each src rdy.
  - An entry woken in cycle t can issue in cycle t.
  - The issue path includes the CDB comparators.
- RS_WAKEUP_ISSUE_EN undefined: issue uses registered rdy only, one cycle later.

Decomposition:
- sys_defs header holds `N, `RS_NUM_ENTRIES, `PR_TAG_W and the payload width define.
- rs_entry sub-module:
  - one entry's registers and the N-way CDB comparators.
  - outputs: valid, ready, and the gated dest/payload.
- rs_table instantiates RS_SIZE rs_entry copies, two priority_selectors and the free popcount.

Test Plan (N=2, RS_SIZE=8, TAG_W=6):
- Reset, then idle: free_count=8, issue_valid=00 for 5 cycles.
- Dispatch 2 ready instrs (dest 5, 9) -> next cycle issue_valid=11; lane0 dest 5 from entry 0, lane1 dest 9 from entry 7. Next cycle free_count=8.
- Dispatch src1 tag 12 not ready; cdb tag 12 two cycles later -> issue one cycle after the CDB cycle (same cycle with RS_WAKEUP_ISSUE_EN).
- Dispatch tag 20 while cdb tag 20 is valid in the same cycle -> entry issues the next cycle.
- Fill 8 non-ready entries -> free_count=0. Wake 2 -> they issue, and free_count=2 the cycle after.
- Squash with 4 valid entries plus a dispatch in the same cycle -> free_count=8 and issue_valid=00 next cycle.
